// File: rtl/rect_fill_draw.sv
// Filled-rectangle rasteriser feeding the VGA pixel-write port, one pixel per clock.
// Optional screen clipping is enabled with `define RECT_CLIP_EN.
module rect_fill_draw #(
  parameter int                   COORD_W   = 10,
  parameter int                   SIZE_W    = 10,
  parameter int                   COLOUR_W  = 3,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR = '0,
  parameter int                   SCREEN_W  = 160,
  parameter int                   SCREEN_H  = 120
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [COORD_W-1:0]  x_in,
  input  logic [COORD_W-1:0]  y_in,
  input  logic [SIZE_W-1:0]   w_in,
  input  logic [SIZE_W-1:0]   h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                erase,
  output logic                busy,
  output logic                done,
  output logic                writeEn,
  output logic [COORD_W-1:0]  x_out,
  output logic [COORD_W-1:0]  y_out,
  output logic [COLOUR_W-1:0] colour
);

`ifdef RECT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t                state_q;
  logic [COORD_W-1:0]    x0_q, y0_q;
  logic [SIZE_W-1:0]     w_q, h_q, cx_q, cy_q;
  logic [COLOUR_W-1:0]   colour_q;
  logic                  busy_q, done_q, we_q;

  // Clipping compares the unwrapped sum so pixels past the right/bottom edge never alias back on screen.
  function automatic logic on_screen(input logic [COORD_W-1:0] xb, input logic [SIZE_W-1:0] dx,
                                     input logic [COORD_W-1:0] yb, input logic [SIZE_W-1:0] dy);
    logic [COORD_W:0] sx, sy;
    sx = {1'b0, xb} + (COORD_W+1)'(dx);
    sy = {1'b0, yb} + (COORD_W+1)'(dy);
    return !CLIP_EN || ((sx < (COORD_W+1)'(SCREEN_W)) && (sy < (COORD_W+1)'(SCREEN_H)));
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            w_q    <= w_in;
            h_q    <= h_in;
            busy_q <= 1'b1;
            if (w_in == '0 || h_in == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              // Origin is only taken for real draws so x_out/y_out keep the last drawn pixel otherwise.
              state_q  <= DRAW;
              x0_q     <= x_in;
              y0_q     <= y_in;
              cx_q     <= '0;
              cy_q     <= '0;
              colour_q <= erase ? BG_COLOUR : colour_in;
              we_q     <= on_screen(x_in, '0, y_in, '0);
            end
          end
        end
        DRAW: begin
          if (cx_q == w_q - SIZE_W'(1)) begin
            if (cy_q == h_q - SIZE_W'(1)) begin
              // Counters hold on the final pixel so the coordinate outputs keep it.
              state_q <= DONE;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cx_q <= '0;
              cy_q <= cy_q + SIZE_W'(1);
              we_q <= on_screen(x0_q, '0, y0_q, cy_q + SIZE_W'(1));
            end
          end else begin
            cx_q <= cx_q + SIZE_W'(1);
            we_q <= on_screen(x0_q, cx_q + SIZE_W'(1), y0_q, cy_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign writeEn = we_q;
  assign colour  = colour_q;
  assign x_out   = x0_q + COORD_W'(cx_q);
  assign y_out   = y0_q + COORD_W'(cy_q);

endmodule

// File: tb/tb_rect_fill_draw.sv
// Randomised bench for rect_fill_draw against a pixel-list reference model.
module tb_rect_fill_draw;
  localparam int CW = 10;
  localparam int SW = 10;
  localparam int KW = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          erase = 1'b0;
  logic [CW-1:0] x_in = '0, y_in = '0;
  logic [SW-1:0] w_in = '0, h_in = '0;
  logic [KW-1:0] colour_in = '0;
  logic          busy, done, writeEn;
  logic [CW-1:0] x_out, y_out;
  logic [KW-1:0] colour;

  int n_chk  = 0;
  int n_pass = 0;
  int last_x = 0;
  int last_y = 0;

  always #5 clk = ~clk;

  rect_fill_draw #(.COORD_W(CW), .SIZE_W(SW), .COLOUR_W(KW), .BG_COLOUR(3'b000),
                   .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .resetn(resetn), .start(start), .x_in(x_in), .y_in(y_in),
    .w_in(w_in), .h_in(h_in), .colour_in(colour_in), .erase(erase),
    .busy(busy), .done(done), .writeEn(writeEn), .x_out(x_out), .y_out(y_out),
    .colour(colour)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
  endtask

  // Called at a negedge; returns at the negedge of the first IDLE cycle after DONE.
  task automatic run_req(input int x, input int y, input int w, input int h, input int col,
                         input bit er, input bit noisy, input bit chain);
    int  ex_q[$];
    int  ey_q[$];
    bit  ew_q[$];
    int  ecol;
    ecol = er ? 0 : col;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        ex_q.push_back((x + c) % (1 << CW));
        ey_q.push_back((y + r) % (1 << CW));
`ifdef RECT_CLIP_EN
        ew_q.push_back(((x + c) < 160) && ((y + r) < 120));
`else
        ew_q.push_back(1'b1);
`endif
      end
    x_in = CW'(x); y_in = CW'(y); w_in = SW'(w); h_in = SW'(h);
    colour_in = KW'(col); erase = er; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < ex_q.size(); i++) begin
      @(negedge clk);
      check("writeEn", writeEn, ew_q[i]);
      if (ew_q[i]) begin
        check("x_out", x_out, ex_q[i]);
        check("y_out", y_out, ey_q[i]);
        check("colour", colour, ecol);
      end
      check("busy_draw", busy, 1);
      check("done_draw", done, 0);
      if (noisy) begin
        start = 1'($urandom); x_in = CW'($urandom); y_in = CW'($urandom);
        w_in = SW'($urandom); h_in = SW'($urandom);
        colour_in = KW'($urandom); erase = 1'($urandom);
      end
    end
    if (ex_q.size() > 0) begin
      last_x = ex_q[ex_q.size()-1];
      last_y = ey_q[ey_q.size()-1];
    end
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_done", busy, 1);
    check("we_done", writeEn, 0);
    check("x_hold", x_out, last_x);
    check("y_hold", y_out, last_y);
    start = chain;
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("done_idle", done, 0);
    check("we_idle", writeEn, 0);
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", writeEn, 0);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_colour", colour, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_req(10, 20, 3, 3, 3'b010, 0, 0, 0);
    run_req(40, 100, 8, 1, 3'b101, 0, 0, 0);
    run_req(40, 100, 1, 4, 3'b101, 0, 0, 0);
    run_req(7, 7, 0, 5, 3'b001, 0, 0, 0);
    run_req(7, 7, 5, 0, 3'b001, 0, 0, 0);
    run_req(30, 30, 4, 3, 3'b111, 1, 1, 1);
    run_req(50, 60, 2, 2, 3'b011, 0, 0, 0);
    run_req(158, 10, 4, 1, 3'b110, 0, 0, 0);
    run_req(1020, 1022, 8, 3, 3'b001, 0, 0, 0);
    run_req(5, 5, 1023, 1, 3'b100, 0, 0, 0);

    for (int k = 0; k < 25; k++)
      run_req($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 7), 1'($urandom),
              1'($urandom), (k < 24) ? 1'($urandom) : 1'b0);

    // Asynchronous reset landing between edges during pixel 4 of 9.
    x_in = 10; y_in = 20; w_in = 3; h_in = 3; colour_in = 3'b010; erase = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("we_pre_rst", writeEn, 1);
    #2 resetn = 1'b0;
    #1;
    check("rst_mid_we", writeEn, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_x", x_out, 0);
    check("rst_mid_colour", colour, 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_we", writeEn, 0);
    end
    last_x = 0;
    last_y = 0;
    run_req(100, 50, 2, 3, 3'b101, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
